// File: rtl/vrf_bram_pkg.sv
// Shared constants and helpers for the VRF BRAM read path.
// Holds default widths, the read-latency enum and the credit width helper.
package vrf_bram_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 9;

  typedef enum int {
    LAT_LOW  = 1,
    LAT_HIGH = 2
  } rd_latency_e;

  // Bits needed to hold a count in 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO holding returned BRAM read words.
// Ports: clk, rstn (async low), flush, push/din, pop/dout, count.
module sync_fifo_fwft
  import vrf_bram_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = 4,
  localparam int CW         = cnt_width(DEPTH),
  localparam int PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  not_empty;
  logic                  do_pop;

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)
        rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= din;
  end

  assign dout = not_empty ? mem[rd_ptr] : '0;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rstn || flush)
    !(push && !do_pop && count == CW'(DEPTH))
  );

endmodule

// File: rtl/bram_rd_stream.sv
// Valid/ready read front end for the port-B side of the VRF BRAM.
// Ports: clk, rstn, flush; req_*; rsp_*; bram_* port-B; busy.
// Optional macro BRAM_RD_BYPASS_EN: zero-storage bypass when FIFO empty.
module bram_rd_stream
  import vrf_bram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_LATENCY = int'(LAT_HIGH),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  bram_enb,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  output logic                  bram_regceb,
  output logic                  bram_rstb,
  input  logic [DATA_WIDTH-1:0] bram_doutb,
  output logic                  busy
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam int SW = CW + 1;

  logic [RD_LATENCY-1:0] vpipe;
  logic                  rdy_en_q;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [SW-1:0]         inflight;
  logic [SW-1:0]         used;
  logic                  accept;
  logic                  arrive;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_nempty;

  // Holds req_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      rdy_en_q <= 1'b0;
    else
      rdy_en_q <= 1'b1;
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < RD_LATENCY; k++)
      inflight = inflight + SW'(vpipe[k]);
  end

  // Credits use registered state only, so a pop frees
  // its slot one cycle later and rsp_ready never feeds req_ready.
  assign used      = SW'(fifo_count) + inflight;
  assign req_ready = rdy_en_q && !flush &&
                     (used < SW'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;

  assign bram_enb    = accept;
  assign bram_addrb  = req_addr;
  assign bram_rstb   = 1'b0;
  assign bram_regceb = (RD_LATENCY == 2) ? vpipe[0] : 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vpipe <= '0;
    end else if (flush) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= accept;
      for (int k = 1; k < RD_LATENCY; k++)
        vpipe[k] <= vpipe[k-1];
    end
  end

  assign arrive      = vpipe[RD_LATENCY-1];
  assign fifo_nempty = (fifo_count != '0);

`ifdef BRAM_RD_BYPASS_EN
  logic byp;

  // Arriving word goes straight out when nothing is queued ahead.
  assign byp       = arrive && !fifo_nempty && !flush;
  assign rsp_valid = fifo_nempty || byp;
  assign rsp_data  = byp ? bram_doutb : fifo_dout;
  assign fifo_push = arrive && !(byp && rsp_ready);
  assign fifo_pop  = fifo_nempty && rsp_ready;
`else
  assign rsp_valid = fifo_nempty;
  assign rsp_data  = fifo_dout;
  assign fifo_push = arrive;
  assign fifo_pop  = fifo_nempty && rsp_ready;
`endif

  assign busy = (|vpipe) || fifo_nempty;

  sync_fifo_fwft #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bram_doutb),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_bram_rd_stream.sv
// Directed self-checking bench for bram_rd_stream.
// Drives a 2-cycle BRAM model behind the port-B controls.
module tb_bram_rd_stream;

`ifdef BRAM_RD_BYPASS_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 3;
`endif

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [8:0]  req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        bram_enb;
  logic [8:0]  bram_addrb;
  logic        bram_regceb;
  logic        bram_rstb;
  logic [63:0] bram_doutb;
  logic        busy;

  bram_rd_stream dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .bram_enb    (bram_enb),
    .bram_addrb  (bram_addrb),
    .bram_regceb (bram_regceb),
    .bram_rstb   (bram_rstb),
    .bram_doutb  (bram_doutb),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ew(input int a);
    if (a == 5)
      return 64'hA5A5;
    return {32'hD00D_0000 + 32'(a),
            32'h5A5A_0000 ^ 32'(a)};
  endfunction

  logic [63:0] mem [512];
  logic [63:0] lat1;

  always @(posedge clk) begin
    if (bram_enb)
      lat1 <= mem[bram_addrb];
    if (bram_regceb)
      bram_doutb <= lat1;
  end

  int n_chk;
  int n_pass;
  int cyc;
  int acc_n;
  int last_acc;
  int lat;
  logic [63:0] got_q [$];
  int          got_cyc [$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    #1;
    if (req_valid && req_ready) begin
      acc_n++;
      last_acc = cyc;
    end
    if (rsp_valid && rsp_ready) begin
      got_q.push_back(rsp_data);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr();
    got_q.delete();
    got_cyc.delete();
    acc_n    = 0;
    last_acc = -1;
    cyc      = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    for (int i = 0; i < 512; i++)
      mem[i] = ew(i);
    lat1 = '0;
    bram_doutb = '0;
    rstn = 1'b0;
    flush = 1'b0;
    req_valid = 1'b1;
    req_addr = '0;
    rsp_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_enb", bram_enb, 0);
    chk("rst_rvalid", rsp_valid, 0);
    chk("rst_rdata", rsp_data, 0);
    chk("rst_regce", bram_regceb, 0);
    chk("rst_busy", busy, 0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", req_ready, 1);
    chk("idle_rvalid", rsp_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_enb", bram_enb, 0);
    chk("idle_rstb", bram_rstb, 0);

    // Single read
    clr();
    req_valid = 1'b1;
    req_addr = 9'd5;
    #1;
    chk("one_enb", bram_enb, 1);
    chk("one_addrb", bram_addrb, 5);
    step();
    req_valid = 1'b0;
    #1;
    chk("one_busy", busy, 1);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("one_lat", lat, EXP_LAT);
    chk("one_data", rsp_data, 64'hA5A5);
    rsp_ready = 1'b1;
    step();
    chk("one_done_rv", rsp_valid, 0);
    chk("one_done_busy", busy, 0);

    // Streaming 16 back-to-back reads
    clr();
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && got_q.size() < 16; i++) begin
      req_valid = (acc_n < 16);
      req_addr = 9'(acc_n);
      step();
    end
    req_valid = 1'b0;
    chk("strm_acc", acc_n, 16);
    chk("strm_nostall", last_acc, 15);
    chk("strm_cnt", got_q.size(), 16);
    chk("strm_first", (got_q.size() > 0) ? got_cyc[0] : -1,
        EXP_LAT);
    chk("strm_bubble",
        (got_q.size() == 16) ? got_cyc[15] - got_cyc[0] : -1,
        15);
    for (int i = 0; i < got_q.size(); i++)
      chk($sformatf("strm_d%0d", i), got_q[i], ew(i));

    // Backpressure
    clr();
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_addr = 9'(20 + acc_n);
      step();
    end
    chk("bp_acc", acc_n, 4);
    chk("bp_ready0", req_ready, 0);
    chk("bp_head", rsp_data, ew(20));
    req_addr = 9'(20 + acc_n);
    rsp_ready = 1'b1;
    #1;
    chk("bp_no_comb", req_ready, 0);
    step();
    chk("bp_resume", req_ready, 1);
    step();
    req_valid = 1'b0;
    repeat (8) step();
    chk("bp_acc2", acc_n, 5);
    chk("bp_cnt", got_q.size(), 5);
    for (int i = 0; i < got_q.size(); i++)
      chk($sformatf("bp_d%0d", i), got_q[i], ew(20 + i));

    // Flush with 2 in flight and 2 queued
    clr();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr = 9'(40 + i);
      step();
    end
    chk("fl_acc", acc_n, 4);
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl_ready", req_ready, 0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_rvalid", rsp_valid, 0);
    chk("fl_busy", busy, 0);
    rsp_ready = 1'b1;
    repeat (4) step();
    chk("fl_stale", got_q.size(), 0);
    req_valid = 1'b1;
    req_addr = 9'd7;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    chk("fl_next_cnt", got_q.size(), 1);
    chk("fl_next_d", (got_q.size() > 0) ? got_q[0] : '1,
        ew(7));

    // Async reset with FIFO full
    clr();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr = 9'd60;
    repeat (9) step();
    chk("ar_full_acc", acc_n, 4);
    chk("ar_pre_rv", rsp_valid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_rvalid", rsp_valid, 0);
    chk("ar_enb", bram_enb, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ready", req_ready, 0);
    #3 rstn = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("ar_post_rv", rsp_valid, 0);
    chk("ar_post_busy", busy, 0);
    chk("ar_post_rdy", req_ready, 1);
    clr();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr = 9'd9;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    chk("ar_next_cnt", got_q.size(), 1);
    chk("ar_next_d", (got_q.size() > 0) ? got_q[0] : '1,
        ew(9));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
